memory_port_arbiter: RTL and testbench

//  Shares one 32-bit external memory port between the instruction-fetch (I) and load/store (D) sides.

---
 rtl/memory_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : memory_port_arbiter
// Description : Shares one 32-bit memory port between the fetch (I) and
//               load/store (D) sides, one req/ack transaction at a time.
//               Define MEMORY_PORT_ARBITER_TIMEOUT_EN to abort stalled accesses.
// Revision    : 1.0 - initial release
//==============================================================================
module memory_port_arbiter #(
    parameter int STREAK_MAX = 4
`ifdef MEMORY_PORT_ARBITER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_busy,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_busy,
    output logic        d_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int c_STREAK_W = $clog2(STREAK_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_I = 2'd1,
        ST_OWN_D = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [c_STREAK_W-1:0] r_streak;
    logic                  r_bus_req;
    logic                  r_bus_we;
    logic [3:0]            r_bus_be;
    logic [31:0]           r_bus_addr;
    logic [31:0]           r_bus_wdata;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_release;
    logic                  w_timeout;
    logic                  w_tmo_hit;
    logic                  w_i_wins;

`ifdef MEMORY_PORT_ARBITER_TIMEOUT_EN
    localparam int c_TCNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [c_TCNT_W-1:0] r_tcnt;

    // Counts cycles spent waiting for ack; restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset || (w_next_state != r_state)) begin
            r_tcnt <= '0;
        end else if (r_state != ST_IDLE) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_tcnt == c_TCNT_W'(TIMEOUT_CYCLES - 1));
    assign i_err     = w_timeout && (r_state == ST_OWN_I);
    assign d_err     = w_timeout && (r_state == ST_OWN_D);
`else
    assign w_tmo_hit = 1'b0;
    assign i_err     = 1'b0;
    assign d_err     = 1'b0;
`endif

    // Fairness: a saturated D streak hands the next slot to a waiting fetch.
    assign w_i_wins = i_req && (r_streak == c_STREAK_W'(STREAK_MAX));

    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_release    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (d_req && !w_i_wins) begin
                    w_grant_d    = 1'b1;
                    w_next_state = ST_OWN_D;
                end else if (i_req) begin
                    w_grant_i    = 1'b1;
                    w_next_state = ST_OWN_I;
                end
            end
            ST_OWN_I, ST_OWN_D: begin
                if (bus_ack) begin
                    w_release    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (!((r_state == ST_OWN_I) ? i_req : d_req)) begin
                    w_next_state = ST_DRAIN;
                end else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_release    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus_ack || w_tmo_hit) begin
                    w_release    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak    <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_be    <= 4'h0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
        end else begin
            if (!i_req || w_grant_i) begin
                r_streak <= '0;
            end else if (w_grant_d && (r_streak < c_STREAK_W'(STREAK_MAX))) begin
                r_streak <= r_streak + 1'b1;
            end

            if (w_grant_i) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= 1'b0;
                r_bus_be    <= 4'hF;
                r_bus_addr  <= i_addr;
                r_bus_wdata <= 32'h0;
            end else if (w_grant_d) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= d_we;
                r_bus_be    <= d_be;
                r_bus_addr  <= d_addr;
                r_bus_wdata <= d_wdata;
            end else if (w_release) begin
                r_bus_req   <= 1'b0;
            end
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_be    = r_bus_be;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

    // Read data is only meaningful to the owner in its completion cycle.
    assign i_rdata = ((r_state == ST_OWN_I) && bus_ack) ? bus_rdata : 32'h0;
    assign d_rdata = ((r_state == ST_OWN_D) && bus_ack) ? bus_rdata : 32'h0;
    assign i_busy  = i_req && !((r_state == ST_OWN_I) && (bus_ack || w_timeout));
    assign d_busy  = d_req && !((r_state == ST_OWN_D) && (bus_ack || w_timeout));

endmodule
`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_memory_port_arbiter
// Description : Directed self-checking bench for memory_port_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_memory_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, bus_ack;
    logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
    logic [3:0]  d_be;
    logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
    logic        i_busy, i_err, d_busy, d_err, bus_req, bus_we;
    logic [3:0]  bus_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef MEMORY_PORT_ARBITER_TIMEOUT_EN
    memory_port_arbiter #(.STREAK_MAX(4), .TIMEOUT_CYCLES(8)) dut (
`else
    memory_port_arbiter #(.STREAK_MAX(4)) dut (
`endif
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_busy(i_busy), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_busy(d_busy), .d_err(d_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; bus_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; bus_rdata = 0;
        repeat (3) cyc();
        reset = 1'b0;
        bus_ack = 1'b1;
        #2;
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_bus_req got %b exp 0", bus_req); end
        n_checks++; if ({bus_we, bus_be} !== 5'h0) begin n_fail++; $display("FAIL rst_we_be got %h exp 0", {bus_we, bus_be}); end
        n_checks++; if ({bus_addr, bus_wdata} !== 64'h0) begin n_fail++; $display("FAIL rst_addr_wdata got %h exp 0", {bus_addr, bus_wdata}); end
        n_checks++; if ({i_err, d_err, i_busy, d_busy} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got %b exp 0000", {i_err, d_err, i_busy, d_busy}); end
        cyc();
        n_checks++; if (bus_req !== 1'b0 || dut.r_state !== 2'd0) begin n_fail++; $display("FAIL idle_ack_ignored got req=%b st=%0d exp req=0 st=0", bus_req, dut.r_state); end
        bus_ack = 1'b0;
    endtask

    task automatic test_fetch();
        cyc();
        i_req = 1'b1; i_addr = 32'h0040_0000;
        #2;
        n_checks++; if (i_busy !== 1'b1 || bus_req !== 1'b0) begin n_fail++; $display("FAIL fetch_grant got busy=%b req=%b exp busy=1 req=0", i_busy, bus_req); end
        cyc();
        #2;
        n_checks++; if ({bus_req, bus_we, bus_be} !== 6'b10_1111) begin n_fail++; $display("FAIL fetch_bus_ctl got %b exp 101111", {bus_req, bus_we, bus_be}); end
        n_checks++; if (bus_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL fetch_addr got %h exp 00400000", bus_addr); end
        n_checks++; if (i_busy !== 1'b1) begin n_fail++; $display("FAIL fetch_busy1 got %b exp 1", i_busy); end
        cyc();
        #2;
        n_checks++; if (i_busy !== 1'b1 || bus_req !== 1'b1) begin n_fail++; $display("FAIL fetch_busy2 got busy=%b req=%b exp 1 1", i_busy, bus_req); end
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'h2408_0001;
        #2;
        n_checks++; if (i_busy !== 1'b0) begin n_fail++; $display("FAIL fetch_done_busy got %b exp 0", i_busy); end
        n_checks++; if (i_rdata !== 32'h2408_0001) begin n_fail++; $display("FAIL fetch_rdata got %h exp 24080001", i_rdata); end
        cyc();
        i_req = 1'b0; bus_ack = 1'b0;
        #2;
        n_checks++; if (bus_req !== 1'b0 || dut.r_state !== 2'd0) begin n_fail++; $display("FAIL fetch_release got req=%b st=%0d exp 0 0", bus_req, dut.r_state); end
    endtask

    task automatic test_priority();
        cyc();
        i_req = 1; i_addr = 32'h0040_0004;
        d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h0000_1000; d_wdata = 32'hABCD;
        #2;
        n_checks++; if ({i_busy, d_busy} !== 2'b11) begin n_fail++; $display("FAIL prio_busy got %b exp 11", {i_busy, d_busy}); end
        cyc();
        #2;
        n_checks++; if ({bus_req, bus_we, bus_be} !== 6'b11_0011) begin n_fail++; $display("FAIL prio_d_ctl got %b exp 110011", {bus_req, bus_we, bus_be}); end
        n_checks++; if (bus_wdata !== 32'hABCD || bus_addr !== 32'h1000) begin n_fail++; $display("FAIL prio_d_data got %h/%h exp 0000abcd/00001000", bus_wdata, bus_addr); end
        bus_ack = 1;
        #1;
        n_checks++; if ({i_busy, d_busy} !== 2'b10) begin n_fail++; $display("FAIL prio_d_done got %b exp 10", {i_busy, d_busy}); end
        cyc();
        d_req = 0; bus_ack = 0;
        #2;
        n_checks++; if (bus_req !== 1'b0 || i_busy !== 1'b1) begin n_fail++; $display("FAIL prio_gap got req=%b ib=%b exp 0 1", bus_req, i_busy); end
        cyc();
        #2;
        n_checks++; if ({bus_req, bus_we, bus_be} !== 6'b10_1111 || bus_addr !== 32'h0040_0004) begin n_fail++; $display("FAIL prio_i_grant got %b %h exp 101111 00400004", {bus_req, bus_we, bus_be}, bus_addr); end
        bus_ack = 1; bus_rdata = 32'h1111_2222;
        #1;
        n_checks++; if (i_busy !== 1'b0 || i_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL prio_i_done got %b %h exp 0 11112222", i_busy, i_rdata); end
        cyc();
        i_req = 0; bus_ack = 0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] got;
        int ng, nd;
        logic drop_i, drop_d;
        got = '0; ng = 0; nd = 0; drop_i = 0; drop_d = 0;
        cyc();
        i_req = 1; i_addr = 32'h0040_0008;
        d_req = 1; d_we = 0; d_be = 4'h1; d_addr = 32'h0000_2000;
        for (int c = 0; c < 30; c++) begin
            cyc();
            bus_ack = 0;
            if (drop_i) i_req = 0;
            if (drop_d) d_req = 0;
            drop_i = 0; drop_d = 0;
            if (bus_req) begin
                bus_ack = 1;
                if (bus_be == 4'hF) begin
                    if (ng < 7) got[ng] = 1'b1;
                    drop_i = 1;
                end else begin
                    nd++;
                    if (nd == 6) drop_d = 1;
                end
                ng++;
            end
        end
        bus_ack = 0; i_req = 0; d_req = 0;
        n_checks++; if (ng !== 7) begin n_fail++; $display("FAIL streak_grant_count got %0d exp 7", ng); end
        for (int k = 0; k < 7; k++) begin
            n_checks++; if (got[k] !== (k == 4)) begin n_fail++; $display("FAIL streak_order[%0d] got I=%b exp I=%b", k, got[k], (k == 4)); end
        end
    endtask

    task automatic test_drain();
        cyc();
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0000_2000;
        cyc();
        d_req = 0;
        #2;
        n_checks++; if (dut.r_state !== 2'd2 || bus_req !== 1'b1 || d_busy !== 1'b0) begin n_fail++; $display("FAIL drain_own got st=%0d req=%b db=%b exp 2 1 0", dut.r_state, bus_req, d_busy); end
        cyc();
        d_req = 1; d_addr = 32'h0000_3000;
        #2;
        n_checks++; if (dut.r_state !== 2'd3 || bus_req !== 1'b1 || bus_addr !== 32'h2000) begin n_fail++; $display("FAIL drain_hold got st=%0d req=%b addr=%h exp 3 1 00002000", dut.r_state, bus_req, bus_addr); end
        cyc();
        bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
        #2;
        n_checks++; if (d_busy !== 1'b1) begin n_fail++; $display("FAIL drain_ack_busy got %b exp 1", d_busy); end
        cyc();
        bus_ack = 0;
        #2;
        n_checks++; if (dut.r_state !== 2'd0 || bus_req !== 1'b0 || d_busy !== 1'b1) begin n_fail++; $display("FAIL drain_idle got st=%0d req=%b db=%b exp 0 0 1", dut.r_state, bus_req, d_busy); end
        cyc();
        bus_ack = 1; bus_rdata = 32'h3333_0000;
        #2;
        n_checks++; if (bus_addr !== 32'h3000 || d_busy !== 1'b0 || d_rdata !== 32'h3333_0000) begin n_fail++; $display("FAIL drain_next got %h %b %h exp 00003000 0 33330000", bus_addr, d_busy, d_rdata); end
        cyc();
        d_req = 0; bus_ack = 0;
    endtask

    task automatic test_reset_mid();
        cyc();
        i_req = 1; i_addr = 32'h0000_0500;
        cyc();
        #2;
        n_checks++; if (dut.r_state !== 2'd1 || bus_req !== 1'b1) begin n_fail++; $display("FAIL rmid_own got st=%0d req=%b exp 1 1", dut.r_state, bus_req); end
        reset = 1;
        cyc();
        reset = 0;
        #2;
        n_checks++; if (bus_req !== 1'b0 || dut.r_state !== 2'd0 || i_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_reset got req=%b st=%0d ib=%b exp 0 0 1", bus_req, dut.r_state, i_busy); end
        cyc();
        bus_ack = 1; bus_rdata = 32'h0000_55AA;
        #2;
        n_checks++; if (bus_addr !== 32'h500 || i_busy !== 1'b0 || i_rdata !== 32'h55AA) begin n_fail++; $display("FAIL rmid_retry got %h %b %h exp 00000500 0 000055aa", bus_addr, i_busy, i_rdata); end
        cyc();
        i_req = 0; bus_ack = 0;
    endtask

`ifdef MEMORY_PORT_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        cyc();
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0000_4000;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            #2;
            if (k < 8) begin
                n_checks++; if ({d_err, d_busy, bus_req} !== 3'b011) begin n_fail++; $display("FAIL tmo_wait[%0d] got %b exp 011", k, {d_err, d_busy, bus_req}); end
            end else begin
                n_checks++; if ({d_err, d_busy, d_rdata} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL tmo_hit got err=%b busy=%b rd=%h exp 1 0 0", d_err, d_busy, d_rdata); end
            end
        end
        cyc();
        d_req = 0;
        #2;
        n_checks++; if ({bus_req, d_err} !== 2'b00) begin n_fail++; $display("FAIL tmo_release got %b exp 00", {bus_req, d_err}); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_back_to_back();
        test_drain();
        test_reset_mid();
`ifdef MEMORY_PORT_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
